// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, control-field encodings and the
// control bundle carried from decode into execute.
package riscv_decode_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } write_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic       reg_write;
        imm_src_e   imm_src;
        logic       alu_src;
        logic       alu_src_a_pc;
        write_src_e write_src;
        logic       branch;
        logic       jump;
        logic       jump_reg;
        logic       mem_read;
        logic       mem_write;
        alu_op_e    alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        reg_write:    1'b0,
        imm_src:      IMM_I,
        alu_src:      1'b0,
        alu_src_a_pc: 1'b0,
        write_src:    WB_ALU,
        branch:       1'b0,
        jump:         1'b0,
        jump_reg:     1'b0,
        mem_read:     1'b0,
        mem_write:    1'b0,
        alu_op:       ALUOP_ADD
    };

    function automatic logic opcode_listed(input logic [6:0] opc);
        case (opc)
            OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP, OPC_LOAD,
            OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC: opcode_listed = 1'b1;
            default:                                   opcode_listed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_core.sv
// Combinational RV32I main decoder: opcode to control bundle.
// Optional DECODE_ILLEGAL_TRAP_EN adds an illegal-instruction flag.
module main_decode_core
    import riscv_decode_pkg::*;
(
    input  logic [31:0] instr_i,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic        illegal_o,
`endif
    output ctrl_t       ctrl_o
);

    logic [6:0] opcode;
    assign opcode = instr_i[6:0];

    always_comb begin
        ctrl_o = CTRL_NOP;
        if (instr_i[1:0] == 2'b11) begin
            case (opcode)
                OPC_JAL: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.imm_src   = IMM_J;
                    ctrl_o.write_src = WB_PC4;
                    ctrl_o.jump      = 1'b1;
                end
                OPC_JALR: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.imm_src   = IMM_I;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.write_src = WB_PC4;
                    ctrl_o.jump      = 1'b1;
                    ctrl_o.jump_reg  = 1'b1;
                end
                OPC_OP_IMM: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.alu_op    = ALUOP_FUNCT;
                end
                OPC_OP: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_op    = ALUOP_FUNCT;
                end
                OPC_LOAD: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.write_src = WB_MEM;
                    ctrl_o.mem_read  = 1'b1;
                end
                OPC_STORE: begin
                    ctrl_o.imm_src   = IMM_S;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.mem_write = 1'b1;
                end
                OPC_BRANCH: begin
                    ctrl_o.imm_src   = IMM_B;
                    ctrl_o.branch    = 1'b1;
                    ctrl_o.alu_op    = ALUOP_SUB;
                end
                OPC_LUI: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.imm_src   = IMM_U;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.write_src = WB_IMM;
                end
                OPC_AUIPC: begin
                    ctrl_o.reg_write    = 1'b1;
                    ctrl_o.imm_src      = IMM_U;
                    ctrl_o.alu_src      = 1'b1;
                    ctrl_o.alu_src_a_pc = 1'b1;
                end
                default: ctrl_o = CTRL_NOP;
            endcase
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    // All-zero and all-one words are trapped explicitly as common fetch garbage.
    assign illegal_o = (instr_i[1:0] != 2'b11) || !opcode_listed(opcode) ||
                       (instr_i == 32'h0000_0000) || (instr_i == 32'hFFFF_FFFF);
`else
    logic unused_upper;
    assign unused_upper = ^instr_i[31:7];
`endif

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: one-entry ID/EX register with valid/ready,
// stall and flush. Optional illegal_o port under DECODE_ILLEGAL_TRAP_EN.
module decode_stage
    import riscv_decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int IMM_SRC_W = 3,
    parameter int ALU_OP_W  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [31:0]          instr_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic                 flush_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [XLEN-1:0]      pc_o,
    output logic [4:0]           rd_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
    output logic [2:0]           funct3_o,
    output logic                 funct7b5_o,
    output logic                 reg_write_o,
    output logic [IMM_SRC_W-1:0] imm_src_o,
    output logic                 alu_src_o,
    output logic                 alu_src_a_pc_o,
    output logic [1:0]           write_src_o,
    output logic                 branch_o,
    output logic                 jump_o,
    output logic                 jump_reg_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                 illegal_o,
`endif
    output logic [ALU_OP_W-1:0]  alu_op_o
);

    ctrl_t           dec_ctrl;
    logic            load;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            funct7b5_q, funct7b5_d;
    ctrl_t           ctrl_q, ctrl_d;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic            dec_illegal;
    logic            illegal_q, illegal_d;

    main_decode_core u_core (
        .instr_i   (instr_i),
        .illegal_o (dec_illegal),
        .ctrl_o    (dec_ctrl)
    );
`else
    main_decode_core u_core (
        .instr_i (instr_i),
        .ctrl_o  (dec_ctrl)
    );
`endif

    assign ready_o = !valid_q || ready_i;
    assign load    = valid_i && ready_o;

    // Flush beats load and hold; a plain drain only drops valid.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        ctrl_d     = ctrl_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d    = 1'b1;
            pc_d       = pc_i;
            rd_d       = instr_i[11:7];
            rs1_d      = instr_i[19:15];
            rs2_d      = instr_i[24:20];
            funct3_d   = instr_i[14:12];
            funct7b5_d = instr_i[30];
            ctrl_d     = dec_ctrl;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_d  = dec_illegal;
`endif
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            ctrl_q     <= CTRL_NOP;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            ctrl_q     <= ctrl_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    assign valid_o        = valid_q;
    assign pc_o           = pc_q;
    assign rd_o           = rd_q;
    assign rs1_o          = rs1_q;
    assign rs2_o          = rs2_q;
    assign funct3_o       = funct3_q;
    assign funct7b5_o     = funct7b5_q;
    assign reg_write_o    = ctrl_q.reg_write;
    assign imm_src_o      = IMM_SRC_W'(ctrl_q.imm_src);
    assign alu_src_o      = ctrl_q.alu_src;
    assign alu_src_a_pc_o = ctrl_q.alu_src_a_pc;
    assign write_src_o    = ctrl_q.write_src;
    assign branch_o       = ctrl_q.branch;
    assign jump_o         = ctrl_q.jump;
    assign jump_reg_o     = ctrl_q.jump_reg;
    assign mem_read_o     = ctrl_q.mem_read;
    assign mem_write_o    = ctrl_q.mem_write;
    assign alu_op_o       = ALU_OP_W'(ctrl_q.alu_op);
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal_o      = illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver pushes expected bundles, a
// negedge monitor compares whatever the stage presents.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] pc_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o;
    logic        funct7b5_o, reg_write_o, alu_src_o, alu_src_a_pc_o;
    logic [2:0]  imm_src_o;
    logic [1:0]  write_src_o, alu_op_o;
    logic        branch_o, jump_o, jump_reg_o, mem_read_o, mem_write_o;
    logic        illegal_act;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .instr_i        (instr_i),
        .pc_i           (pc_i),
        .flush_i        (flush_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .pc_o           (pc_o),
        .rd_o           (rd_o),
        .rs1_o          (rs1_o),
        .rs2_o          (rs2_o),
        .funct3_o       (funct3_o),
        .funct7b5_o     (funct7b5_o),
        .reg_write_o    (reg_write_o),
        .imm_src_o      (imm_src_o),
        .alu_src_o      (alu_src_o),
        .alu_src_a_pc_o (alu_src_a_pc_o),
        .write_src_o    (write_src_o),
        .branch_o       (branch_o),
        .jump_o         (jump_o),
        .jump_reg_o     (jump_reg_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal_o      (illegal_act),
`endif
        .alu_op_o       (alu_op_o)
    );

`ifndef DECODE_ILLEGAL_TRAP_EN
    assign illegal_act = 1'b0;
`endif

    // Reference decode table, columns in order:
    // reg_write, imm_src, alu_src, write_src, branch, alu_op, jump,
    // mem_read, mem_write, jump_reg, alu_src_a_pc
    logic [6:0]  opc_tab [9] = '{7'b1101111, 7'b1100111, 7'b0010011,
                                 7'b0110011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b0110111, 7'b0010111};
    logic [14:0] ctl_tab [9] = '{15'b1_011_0_10_0_00_1_0_0_0_0,
                                 15'b1_000_1_10_0_00_1_0_0_1_0,
                                 15'b1_000_1_00_0_10_0_0_0_0_0,
                                 15'b1_000_0_00_0_10_0_0_0_0_0,
                                 15'b1_000_1_01_0_00_0_1_0_0_0,
                                 15'b0_001_1_00_0_00_0_0_1_0_0,
                                 15'b0_010_0_00_1_01_0_0_0_0_0,
                                 15'b1_100_1_11_0_00_0_0_0_0_0,
                                 15'b1_100_1_00_0_00_0_0_0_0_1};

    typedef struct {
        logic [31:0] pc;
        logic [14:0] regs;
        logic [3:0]  fn;
        logic [14:0] ctrl;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t pend_exp;
    logic pend = 1'b0;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic found = 1'b0;
        e.pc   = pc;
        e.regs = {ins[11:7], ins[19:15], ins[24:20]};
        e.fn   = {ins[14:12], ins[30]};
        e.ctrl = '0;
        if (ins[1:0] == 2'b11) begin
            for (int i = 0; i < 9; i++) begin
                if (ins[6:0] == opc_tab[i]) begin
                    e.ctrl = ctl_tab[i];
                    found  = 1'b1;
                end
            end
        end
        e.ill = !found || ins == 32'h0 || ins == 32'hFFFF_FFFF;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Push the transfer decided for the edge that just happened, then drive the next cycle.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl, input logic rs);
        @(posedge clk);
        if (pend) sb.push_back(pend_exp);
        #1;
        valid_i  = v;
        instr_i  = ins;
        pc_i     = pc;
        ready_i  = rdy;
        flush_i  = fl;
        rst_i    = rs;
        pend     = v && !fl && !rs && (sb.size() == 0 || rdy);
        pend_exp = model(ins, pc);
    endtask

    logic [14:0] act_ctrl;
    assign act_ctrl = {reg_write_o, imm_src_o, alu_src_o, write_src_o, branch_o, alu_op_o,
                       jump_o, mem_read_o, mem_write_o, jump_reg_o, alu_src_a_pc_o};

    logic rst_prev = 1'b1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_prev) begin
                chk("reset_outputs", {valid_o, pc_o, rd_o, rs1_o, rs2_o, funct3_o, funct7b5_o,
                                      act_ctrl, illegal_act}, '0);
            end
            chk("valid_o", valid_o, sb.size() != 0);
            chk("ready_o", ready_o, sb.size() == 0 || ready_i);
            if (valid_o && sb.size() != 0) begin
                chk("pc_o", pc_o, sb[0].pc);
                chk("regs", {rd_o, rs1_o, rs2_o}, sb[0].regs);
                chk("funct", {funct3_o, funct7b5_o}, sb[0].fn);
                chk("ctrl", act_ctrl, sb[0].ctrl);
`ifdef DECODE_ILLEGAL_TRAP_EN
                chk("illegal_o", illegal_act, sb[0].ill);
`endif
            end
            if (rst_i) sb.delete();
            else if (sb.size() != 0 && (ready_i || flush_i)) void'(sb.pop_front());
            rst_prev = rst_i;
        end
    end

    initial begin
        logic [31:0] r, ins;
        int k;
        drive(0, 32'h0, 32'h0, 0, 0, 1);
        mon_en = 1'b1;
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        // addi, then jal + auipc back to back
        drive(1, 32'h00500093, 32'h100, 1, 0, 0);
        drive(1, 32'h008000EF, 32'h104, 1, 0, 0);
        drive(1, 32'h00001117, 32'h108, 1, 0, 0);
        // sw held for three stalled cycles while fetch offers another word
        drive(1, 32'h00112023, 32'h10C, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 32'h00500093, 32'h110, 0, 0, 0);
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        // flushed beq, then a normal instruction
        drive(1, 32'h00208463, 32'h200, 1, 1, 0);
        drive(1, 32'h00500093, 32'h204, 1, 0, 0);
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        // all-zero and all-one words
        drive(1, 32'h00000000, 32'h300, 1, 0, 0);
        drive(1, 32'hFFFFFFFF, 32'h304, 1, 0, 0);
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        // reset during a stall
        drive(1, 32'h00112023, 32'h400, 0, 0, 0);
        drive(1, 32'h00500093, 32'h404, 0, 0, 0);
        drive(1, 32'h00500093, 32'h404, 0, 0, 1);
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            k = $urandom_range(0, 12);
            if (k < 9) ins = {r[31:7], opc_tab[k]};
            else if (k == 9) ins = r;
            else if (k == 10) ins = 32'h0;
            else if (k == 11) ins = 32'hFFFF_FFFF;
            else ins = {r[31:2], 2'b01};
            drive($urandom_range(0, 3) != 0, ins, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 4; i++) drive(0, 32'h0, 32'h0, 1, 0, 0);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
